// File: rtl/if_bus_if_pkg.sv
// Shared types and widths for the instruction-fetch bus interface.
// Latency: none (declarations only).
// Backpressure: n/a.
package if_bus_if_pkg;

   localparam int INST_ADDR_W  = 32;
   localparam int INST_W       = 32;
   localparam int STALL_W      = 6;
   localparam int STALL_IF_BIT = 1;

   localparam logic [INST_W-1:0] ZERO_WORD = '0;

   // IDLE waits for a PC, BUSY owns the bus, HOLD parks a fetched word while the pipe is stalled
   typedef enum logic [1:0] {
      IF_IDLE = 2'b00,
      IF_BUSY = 2'b01,
      IF_HOLD = 2'b10
   } if_state_e;

endpackage

// File: rtl/if_bus_if_if.sv
// Request/acknowledge instruction memory bus between the fetch unit and memory.
// Latency: none (wires only).
// Backpressure: memory stretches a transaction by withholding bus_ack_i.
interface if_bus_if_if;
   import if_bus_if_pkg::*;

   logic                   bus_req_o;
   logic [INST_ADDR_W-1:0] bus_addr_o;
   logic                   bus_ack_i;
   logic [INST_W-1:0]      bus_data_i;

   // fetch side issues requests
   modport master (
      output bus_req_o,
      output bus_addr_o,
      input  bus_ack_i,
      input  bus_data_i
   );

   // memory side answers them
   modport slave (
      input  bus_req_o,
      input  bus_addr_o,
      output bus_ack_i,
      output bus_data_i
   );

endinterface

// File: rtl/if_bus_if.sv
// Turns each fetch PC into a memory bus transaction and stalls the core until it returns.
// Latency: 2 cycles per fetch with a zero-wait memory, N+2 with N wait states.
// Backpressure: stallreq_o held while waiting; a returned word is parked while stall_i[1] is high.
module if_bus_if
   import if_bus_if_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [INST_ADDR_W-1:0] cpu_addr_i,
   input  logic                   cpu_ce_i,
   input  logic [STALL_W-1:0]     stall_i,
   output logic [INST_W-1:0]      cpu_data_o,
   output logic                   stallreq_o,
   if_bus_if_if.master            bus,
   output logic                   fetch_err_o
);

   localparam int            CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   if_state_e              state_q, state_d;
   logic                   req_q, req_d;
   logic [INST_ADDR_W-1:0] addr_q, addr_d;
   logic [INST_W-1:0]      buf_q, buf_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   err_q, err_d;
   logic                   fetch_held;

   // only the fetch-stage bit of the stall vector matters here
   logic unused_stall;
   assign unused_stall = ^{stall_i[STALL_W-1:STALL_IF_BIT+1], stall_i[STALL_IF_BIT-1:0]};
   assign fetch_held   = stall_i[STALL_IF_BIT];

   assign bus.bus_req_o  = req_q;
   assign bus.bus_addr_o = addr_q;
   assign fetch_err_o    = err_q;

   // state and bus registers; reset drops the request without waiting for a clock
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IF_IDLE;
         req_q   <= 1'b0;
         addr_q  <= '0;
         buf_q   <= ZERO_WORD;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // next state and core-facing outputs; stallreq_o never looks at stall_i so ctrl sees no loop
   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      addr_d     = addr_q;
      buf_d      = buf_q;
      cnt_d      = cnt_q;
      err_d      = 1'b0;
      stallreq_o = 1'b0;
      cpu_data_o = ZERO_WORD;

      case (state_q)
         IF_IDLE: begin
            if (cpu_ce_i) begin
               req_d      = 1'b1;
               addr_d     = cpu_addr_i;
               cnt_d      = '0;
               state_d    = IF_BUSY;
               stallreq_o = 1'b1;
            end
         end
         IF_BUSY: begin
            if (bus.bus_ack_i) begin
               // ack wins over a timeout landing in the same cycle
               req_d   = 1'b0;
               buf_d   = bus.bus_data_i;
               state_d = (cpu_ce_i && fetch_held) ? IF_HOLD : IF_IDLE;
               if (cpu_ce_i) begin
                  cpu_data_o = bus.bus_data_i;
               end
            end else if (cnt_q == CNT_LAST) begin
               // abandon the bus and hand the core a NOP
               req_d   = 1'b0;
               buf_d   = ZERO_WORD;
               err_d   = 1'b1;
               state_d = (cpu_ce_i && fetch_held) ? IF_HOLD : IF_IDLE;
            end else begin
               stallreq_o = 1'b1;
               cnt_d      = cnt_q + CW'(1);
            end
         end
         IF_HOLD: begin
            cpu_data_o = buf_q;
            if (!fetch_held) begin
               state_d = IF_IDLE;
            end
         end
         default: begin
            state_d = IF_IDLE;
         end
      endcase

      // while reset is held the block presents nothing to the core
      if (!rst) begin
         stallreq_o = 1'b0;
         cpu_data_o = ZERO_WORD;
      end
   end

endmodule

// File: tb/tb_if_bus_if.sv
// Scoreboarded bench for the fetch bus interface: zero/N-wait fetches, hold, timeout, reset, idle.
// Latency: checks fetch timing cycle by cycle against a 2 / N+2 cycle expectation.
// Backpressure: drives stall_i and withholds bus_ack_i to exercise hold and timeout.
module tb_if_bus_if;
   import if_bus_if_pkg::*;

   localparam int TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] cpu_addr_i = '0;
   logic        cpu_ce_i = 1'b0;
   logic [5:0]  stall_i = '0;
   logic [31:0] cpu_data_o;
   logic        stallreq_o;
   logic        fetch_err_o;

   int n_checks = 0;
   int n_fails  = 0;
   logic [31:0] exp_q[$];

   if_bus_if_if bus_if ();

   if_bus_if #(.TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .cpu_addr_i  (cpu_addr_i),
      .cpu_ce_i    (cpu_ce_i),
      .stall_i     (stall_i),
      .cpu_data_o  (cpu_data_o),
      .stallreq_o  (stallreq_o),
      .bus         (bus_if),
      .fetch_err_o (fetch_err_o)
   );

   always #5 clk = ~clk;

   // if_id model: whenever the next edge would capture an instruction, it must be the oldest expected one
   always @(negedge clk) begin
      if (rst && cpu_ce_i && !stallreq_o && !stall_i[1]) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fails++;
            $display("FAIL scoreboard_unexpected: captured %h with nothing expected", cpu_data_o);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (cpu_data_o !== e) begin
               n_fails++;
               $display("FAIL scoreboard_capture: got %h expected %h", cpu_data_o, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if ({bus_if.bus_req_o, stallreq_o, fetch_err_o} !== 3'b000) begin
         n_fails++; $display("FAIL reset_flags: got %b expected 000", {bus_if.bus_req_o, stallreq_o, fetch_err_o});
      end
      n_checks++;
      if (bus_if.bus_addr_o !== 32'h0 || cpu_data_o !== 32'h0) begin
         n_fails++; $display("FAIL reset_data: addr %h data %h expected 0 0", bus_if.bus_addr_o, cpu_data_o);
      end
      tick();
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({bus_if.bus_req_o, stallreq_o, cpu_data_o} !== 34'h0) begin
         n_fails++; $display("FAIL reset_release_idle: req %b stallreq %b data %h expected 0", bus_if.bus_req_o, stallreq_o, cpu_data_o);
      end
      tick();
   endtask

   task automatic test_zero_wait();
      logic [31:0] pcs[2];
      logic [31:0] rom[2];
      pcs = '{32'h0000_0000, 32'h0000_0004};
      rom = '{32'h3401_1100, 32'h3402_0020};
      for (int i = 0; i < 2; i++) begin
         cpu_ce_i = 1'b1; cpu_addr_i = pcs[i]; bus_if.bus_ack_i = 1'b0;
         @(negedge clk);
         n_checks++;
         if ({bus_if.bus_req_o, stallreq_o, fetch_err_o} !== 3'b010 || cpu_data_o !== 32'h0) begin
            n_fails++; $display("FAIL zw_idle_cycle: flags %b data %h expected 010 0", {bus_if.bus_req_o, stallreq_o, fetch_err_o}, cpu_data_o);
         end
         tick();
         bus_if.bus_ack_i = 1'b1; bus_if.bus_data_i = rom[i]; exp_q.push_back(rom[i]);
         @(negedge clk);
         n_checks++;
         if ({bus_if.bus_req_o, stallreq_o, fetch_err_o} !== 3'b100 || bus_if.bus_addr_o !== pcs[i]) begin
            n_fails++; $display("FAIL zw_ack_cycle: flags %b addr %h expected 100 %h", {bus_if.bus_req_o, stallreq_o, fetch_err_o}, bus_if.bus_addr_o, pcs[i]);
         end
         n_checks++;
         if (cpu_data_o !== rom[i]) begin
            n_fails++; $display("FAIL zw_data: got %h expected %h", cpu_data_o, rom[i]);
         end
         tick();
         bus_if.bus_ack_i = 1'b0;
      end
   endtask

   task automatic test_wait_states();
      int hi;
      hi = 0;
      cpu_ce_i = 1'b1; cpu_addr_i = 32'h4; bus_if.bus_ack_i = 1'b0;
      exp_q.push_back(32'h8c22_0000);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (stallreq_o) hi++;
         if (k > 0) begin
            n_checks++;
            if (bus_if.bus_req_o !== 1'b1 || bus_if.bus_addr_o !== 32'h4 || cpu_data_o !== 32'h0) begin
               n_fails++; $display("FAIL ws_busy_hold: req %b addr %h data %h expected 1 00000004 0", bus_if.bus_req_o, bus_if.bus_addr_o, cpu_data_o);
            end
         end
         tick();
      end
      bus_if.bus_ack_i = 1'b1; bus_if.bus_data_i = 32'h8c22_0000;
      @(negedge clk);
      if (stallreq_o) hi++;
      n_checks++;
      if (hi !== 4) begin
         n_fails++; $display("FAIL ws_stall_cycles: got %0d expected 4", hi);
      end
      n_checks++;
      if ({bus_if.bus_req_o, stallreq_o, fetch_err_o} !== 3'b100 || cpu_data_o !== 32'h8c22_0000) begin
         n_fails++; $display("FAIL ws_ack_cycle: flags %b data %h expected 100 8c220000", {bus_if.bus_req_o, stallreq_o, fetch_err_o}, cpu_data_o);
      end
      tick();
      bus_if.bus_ack_i = 1'b0; cpu_addr_i = 32'h8;
      @(negedge clk);
      n_checks++;
      if ({bus_if.bus_req_o, stallreq_o, fetch_err_o} !== 3'b010) begin
         n_fails++; $display("FAIL ws_next_idle: flags %b expected 010", {bus_if.bus_req_o, stallreq_o, fetch_err_o});
      end
      tick();
      bus_if.bus_ack_i = 1'b1; bus_if.bus_data_i = 32'h3c01_0001; exp_q.push_back(32'h3c01_0001);
      @(negedge clk);
      n_checks++;
      if (bus_if.bus_addr_o !== 32'h8) begin
         n_fails++; $display("FAIL ws_next_addr: got %h expected 00000008", bus_if.bus_addr_o);
      end
      tick();
      bus_if.bus_ack_i = 1'b0;
   endtask

   task automatic test_hold();
      cpu_ce_i = 1'b1; cpu_addr_i = 32'hC; bus_if.bus_ack_i = 1'b0;
      exp_q.push_back(32'h0041_001a);
      tick();
      bus_if.bus_ack_i = 1'b1; bus_if.bus_data_i = 32'h0041_001a; stall_i = 6'b000010;
      @(negedge clk);
      n_checks++;
      if ({bus_if.bus_req_o, stallreq_o} !== 2'b10 || cpu_data_o !== 32'h0041_001a) begin
         n_fails++; $display("FAIL hold_ack_cycle: req/stall %b data %h expected 10 0041001a", {bus_if.bus_req_o, stallreq_o}, cpu_data_o);
      end
      tick();
      // a stray ack with garbage while parked must be ignored
      bus_if.bus_data_i = 32'hdead_beef;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_checks++;
         if ({bus_if.bus_req_o, stallreq_o, fetch_err_o} !== 3'b000 || cpu_data_o !== 32'h0041_001a) begin
            n_fails++; $display("FAIL hold_parked: flags %b data %h expected 000 0041001a", {bus_if.bus_req_o, stallreq_o, fetch_err_o}, cpu_data_o);
         end
         tick();
      end
      stall_i = '0; bus_if.bus_ack_i = 1'b0;
      @(negedge clk);
      n_checks++;
      if (cpu_data_o !== 32'h0041_001a || stallreq_o !== 1'b0) begin
         n_fails++; $display("FAIL hold_release: data %h stallreq %b expected 0041001a 0", cpu_data_o, stallreq_o);
      end
      tick();
      cpu_addr_i = 32'h10;
      @(negedge clk);
      n_checks++;
      if ({bus_if.bus_req_o, stallreq_o} !== 2'b01 || cpu_data_o !== 32'h0) begin
         n_fails++; $display("FAIL hold_back_to_idle: req/stall %b data %h expected 01 0", {bus_if.bus_req_o, stallreq_o}, cpu_data_o);
      end
      tick();
      bus_if.bus_ack_i = 1'b1; bus_if.bus_data_i = 32'h2021_0005; exp_q.push_back(32'h2021_0005);
      tick();
      bus_if.bus_ack_i = 1'b0;
   endtask

   task automatic test_timeout();
      cpu_ce_i = 1'b1; cpu_addr_i = 32'h14; bus_if.bus_ack_i = 1'b0;
      exp_q.push_back(32'h0);
      tick();
      for (int k = 0; k < TIMEOUT; k++) begin
         logic [2:0] e;
         e = (k < TIMEOUT - 1) ? 3'b110 : 3'b100;
         @(negedge clk);
         n_checks++;
         if ({bus_if.bus_req_o, stallreq_o, fetch_err_o} !== e || cpu_data_o !== 32'h0) begin
            n_fails++; $display("FAIL to_busy_%0d: flags %b data %h expected %b 0", k, {bus_if.bus_req_o, stallreq_o, fetch_err_o}, cpu_data_o, e);
         end
         tick();
      end
      cpu_addr_i = 32'h18;
      @(negedge clk);
      n_checks++;
      if ({bus_if.bus_req_o, stallreq_o, fetch_err_o} !== 3'b011) begin
         n_fails++; $display("FAIL to_err_pulse: flags %b expected 011", {bus_if.bus_req_o, stallreq_o, fetch_err_o});
      end
      tick();
      bus_if.bus_ack_i = 1'b1; bus_if.bus_data_i = 32'h0000_0020; exp_q.push_back(32'h0000_0020);
      @(negedge clk);
      n_checks++;
      if ({bus_if.bus_req_o, stallreq_o, fetch_err_o} !== 3'b100 || bus_if.bus_addr_o !== 32'h18) begin
         n_fails++; $display("FAIL to_next_fetch: flags %b addr %h expected 100 00000018", {bus_if.bus_req_o, stallreq_o, fetch_err_o}, bus_if.bus_addr_o);
      end
      tick();
      bus_if.bus_ack_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      cpu_ce_i = 1'b1; cpu_addr_i = 32'h20; bus_if.bus_ack_i = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      n_checks++;
      if ({bus_if.bus_req_o, stallreq_o, fetch_err_o} !== 3'b000 || bus_if.bus_addr_o !== 32'h0 || cpu_data_o !== 32'h0) begin
         n_fails++; $display("FAIL rst_async: flags %b addr %h data %h expected 000 0 0", {bus_if.bus_req_o, stallreq_o, fetch_err_o}, bus_if.bus_addr_o, cpu_data_o);
      end
      @(posedge clk);
      #2;
      cpu_addr_i = 32'h24; rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({bus_if.bus_req_o, stallreq_o} !== 2'b01) begin
         n_fails++; $display("FAIL rst_restart_idle: req/stall %b expected 01", {bus_if.bus_req_o, stallreq_o});
      end
      tick();
      bus_if.bus_ack_i = 1'b1; bus_if.bus_data_i = 32'h3403_0044; exp_q.push_back(32'h3403_0044);
      @(negedge clk);
      n_checks++;
      if (bus_if.bus_addr_o !== 32'h24 || bus_if.bus_req_o !== 1'b1) begin
         n_fails++; $display("FAIL rst_restart_addr: addr %h req %b expected 00000024 1", bus_if.bus_addr_o, bus_if.bus_req_o);
      end
      tick();
      bus_if.bus_ack_i = 1'b0;
   endtask

   task automatic test_ce_off();
      cpu_ce_i = 1'b0;
      for (int k = 0; k < 6; k++) begin
         cpu_addr_i = $urandom;
         bus_if.bus_ack_i = 1'($urandom_range(0, 1));
         bus_if.bus_data_i = $urandom;
         @(negedge clk);
         n_checks++;
         if ({bus_if.bus_req_o, stallreq_o, fetch_err_o} !== 3'b000 || cpu_data_o !== 32'h0) begin
            n_fails++; $display("FAIL ce_off_%0d: flags %b data %h expected 000 0", k, {bus_if.bus_req_o, stallreq_o, fetch_err_o}, cpu_data_o);
         end
         tick();
      end
      bus_if.bus_ack_i = 1'b0;
      n_checks++;
      if (exp_q.size() !== 0) begin
         n_fails++; $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
      end
   endtask

   initial begin
      bus_if.bus_ack_i  = 1'b0;
      bus_if.bus_data_i = '0;
      @(posedge clk);
      #2;
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_hold();
      test_timeout();
      test_reset_mid();
      test_ce_off();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/if_bus_if.md
# if_bus_if

Instruction-fetch bus interface between the core's fetch port (pc_reg address/chip-enable and the if_id instruction input) and an external instruction memory with a variable-latency request/acknowledge handshake. Each PC is turned into a bus transaction. The block raises a fetch stall request to ctrl until the instruction returns, and holds a returned instruction while the rest of the pipeline is stalled. A bus that never acknowledges is abandoned after a programmable timeout.

## Interface
Parameters:
- TIMEOUT, 255: maximum BUSY cycles without acknowledge before the fetch is abandoned; counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- cpu_addr_i  in  32  PC from pc_reg. Held stable by ctrl while stallreq_o is high.
- cpu_ce_i  in  1  fetch enable from pc_reg.
- stall_i  in  6  ctrl stall vector; stall_i[1] high = fetch stage held this cycle.
- cpu_data_o  out  32  instruction to if_id.
- stallreq_o  out  1  stall request to ctrl (stallreq_from_if).
- bus_req_o  out  1  registered transaction request.
- bus_addr_o  out  32  registered transaction address.
- bus_ack_i  in  1  memory acknowledge; may be asserted in the first cycle bus_req_o is high.
- bus_data_i  in  32  read data, valid when bus_ack_i is high.
- fetch_err_o  out  1  registered one-cycle pulse on timeout.

## Operation
- Reset values: state IDLE, bus_req_o 0, bus_addr_o 0, data buffer 0, timeout counter 0, fetch_err_o 0.
- FSM states are IDLE, BUSY and HOLD. Registered state, combinational outputs cpu_data_o and stallreq_o.
- IDLE:
  - cpu_ce_i=1: bus_req_o<=1, bus_addr_o<=cpu_addr_i, counter<=0, go BUSY. stallreq_o=1 and cpu_data_o=0 in this cycle.
  - cpu_ce_i=0: stay IDLE, stallreq_o=0, cpu_data_o=0.
- BUSY, bus_ack_i=1:
  - bus_req_o<=0, buffer<=bus_data_i, cpu_data_o=bus_data_i, stallreq_o=0.
  - stall_i[1]=0: go IDLE. if_id captures the instruction on this edge.
  - stall_i[1]=1: go HOLD.
- BUSY, bus_ack_i=0:
  - stallreq_o=1, cpu_data_o=0, counter increments.
  - When counter==TIMEOUT-1: bus_req_o<=0, buffer<=0 (NOP), fetch_err_o<=1 for one cycle, then go HOLD if stall_i[1], else IDLE. cpu_data_o=0 and stallreq_o=0 in that cycle.
- HOLD: cpu_data_o=buffer, stallreq_o=0, bus_req_o=0. Stay while stall_i[1]=1; go IDLE on the first cycle with stall_i[1]=0. if_id consumes the buffer on that edge.
- stallreq_o never depends on stall_i, so there is no combinational loop through ctrl.
- cpu_ce_i dropping during BUSY: the transaction completes or times out normally, the data is discarded, and the FSM goes IDLE rather than HOLD.
- Reset asserted mid-transaction: all state clears immediately and bus_req_o drops asynchronously. The memory must tolerate an abandoned request.
- Ack outside BUSY is ignored.

## Timing
- bus_req_o and bus_addr_o rise on the edge leaving IDLE.
- A zero-wait memory (ack in the first BUSY cycle) gives 2 cycles per instruction. An N-wait memory gives N+2.
- Ack cycle to if_id capture: same edge when unstalled.
- Timeout: fetch_err_o is high in the cycle after the TIMEOUT-th un-acked BUSY cycle.
- fetch_err_o is never high for two consecutive cycles.

## Structure
- Add to define.v: IfIdle/IfBusy/IfHold 2-bit state encodings, reusing existing `InstAddrBus, `InstBus and `ZeroWord.
- Single flat module, no sub-module.
- mips_32 gains the bus ports and a third ctrl input, stallreq_from_if.

## Test plan
- Zero-wait ROM returning 0x34011100 at PC 0x0: bus_req_o is high one cycle, ack in the same cycle, cpu_data_o=0x34011100, stallreq_o pattern 1,0 per fetch, 2 cycles per instruction.
- Memory with 3 wait states at PC 0x4: stallreq_o high for 4 cycles, bus_addr_o=0x4 is held, the instruction is delivered in the ack cycle, next fetch address is 0x8.
- Ack while stall_i[1]=1 for 3 cycles (ex divide stall): HOLD is entered, cpu_data_o holds the value through all stall cycles, no new bus_req_o, IDLE is re-entered when the stall releases.
- TIMEOUT=4 with no ack: bus_req_o drops after 4 BUSY cycles, fetch_err_o pulses once, cpu_data_o=0, stallreq_o falls, the next fetch proceeds.
- rst pulled low in the second BUSY cycle: bus_req_o=0 and state IDLE without a clock edge, all outputs zero; after release, fetch restarts at the PC presented.
- cpu_ce_i=0: no bus_req_o ever, stallreq_o=0, cpu_data_o=0.
